// File: rtl/cnn_conv_sequencer_if.sv
// Beat stream from the convolution loop sequencer to the banked RAM read stage.
// The master drives one vector read request per beat; the slave returns ready.
interface cnn_conv_sequencer_if #(
  parameter int VECTOR_SIZE = 8,
  parameter int ADDR_WIDTH  = 16
);
  logic                   validOut;
  logic                   readyIn;
  logic [ADDR_WIDTH-1:0]  dataAddrOut;
  logic [ADDR_WIDTH-1:0]  filtAddrOut;
  logic [VECTOR_SIZE-1:0] laneEnOut;
  logic                   lastOut;

  modport master (
    output validOut, dataAddrOut, filtAddrOut, laneEnOut, lastOut,
    input  readyIn
  );

  modport slave (
    input  validOut, dataAddrOut, filtAddrOut, laneEnOut, lastOut,
    output readyIn
  );
endinterface

// File: rtl/cnn_conv_sequencer.sv
// Loop controller for the vector MAC: walks row-chunk, filter-column and output-base
// loops and emits one data/filter vector address pair per accepted beat.
module cnn_conv_sequencer #(
  parameter int VECTOR_SIZE = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 startIn,
  input  logic [CNT_WIDTH-1:0] filtRowsIn,
  input  logic [CNT_WIDTH-1:0] filtColsIn,
  input  logic [CNT_WIDTH-1:0] dataRowsIn,
  input  logic [CNT_WIDTH-1:0] numOutIn,
  output logic                 busyOut,
  output logic                 errOut,
  output logic                 doneOut,
  cnn_conv_sequencer_if.master beat
);

  localparam int LOG2V = $clog2(VECTOR_SIZE);
  localparam logic [CNT_WIDTH-1:0]   C_ONE = CNT_WIDTH'(1);
  localparam logic [VECTOR_SIZE-1:0] V_ONE = VECTOR_SIZE'(1);
  localparam logic [ADDR_WIDTH-1:0]  A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  VSTEP = ADDR_WIDTH'(VECTOR_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_e;

  state_e state_q, state_d;
  logic valid_q, valid_d, busy_q, busy_d, err_q, err_d, done_q, done_d, last_q, last_d;
  logic [ADDR_WIDTH-1:0]  filt_q, filt_d, data_q, data_d;
  logic [VECTOR_SIZE-1:0] en_q, en_d, lastMask_q, lastMask_d;
  logic [CNT_WIDTH-1:0]   fRows_q, fRows_d, dRows_q, dRows_d, colsM1_q, colsM1_d, outM1_q, outM1_d;
  logic [CNT_WIDTH-1:0]   nChkM1_q, nChkM1_d, r_q, r_d, c_q, c_d, b_q, b_d;
  logic [ADDR_WIDTH-1:0]  colFilt_q, colFilt_d, colData_q, colData_d, baseData_q, baseData_d;

  logic [LOG2V-1:0]       rem;
  logic [CNT_WIDTH-1:0]   initChkM1;
  logic [VECTOR_SIZE-1:0] initMask;
  logic                   fire, reject;

  // Chunk count and partial-lane mask of the last row chunk, from latched filtRows.
  assign rem       = fRows_q[LOG2V-1:0];
  assign initChkM1 = (fRows_q >> LOG2V) + {{(CNT_WIDTH-1){1'b0}}, (rem != '0)} - C_ONE;
  assign initMask  = (rem == '0) ? '1 : ((V_ONE << rem) - V_ONE);

  assign fire   = valid_q && beat.readyIn;
  assign reject = (filtRowsIn == '0) || (filtColsIn == '0) || (numOutIn == '0) ||
                  (filtRowsIn > dataRowsIn);

  always_comb begin
    state_d = state_q;  valid_d = valid_q;  busy_d = busy_q;  err_d = 1'b0;  done_d = 1'b0;
    last_d = last_q;  filt_d = filt_q;  data_d = data_q;  en_d = en_q;
    lastMask_d = lastMask_q;  nChkM1_d = nChkM1_q;
    fRows_d = fRows_q;  dRows_d = dRows_q;  colsM1_d = colsM1_q;  outM1_d = outM1_q;
    r_d = r_q;  c_d = c_q;  b_d = b_q;
    colFilt_d = colFilt_q;  colData_d = colData_q;  baseData_d = baseData_q;
    case (state_q)
      S_IDLE: begin
        if (startIn) begin
          fRows_d  = filtRowsIn;
          dRows_d  = dataRowsIn;
          colsM1_d = filtColsIn - C_ONE;
          outM1_d  = numOutIn - C_ONE;
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = S_INIT;
            busy_d  = 1'b1;
          end
        end
      end
      S_INIT: begin
        nChkM1_d   = initChkM1;
        lastMask_d = initMask;
        r_d = '0;  c_d = '0;  b_d = '0;
        colFilt_d = '0;  colData_d = '0;  baseData_d = '0;
        filt_d  = '0;
        data_d  = '0;
        en_d    = (initChkM1 == '0) ? initMask : '1;
        last_d  = (initChkM1 == '0) && (colsM1_q == '0);
        valid_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          if (r_q != nChkM1_q) begin
            r_d    = r_q + C_ONE;
            filt_d = filt_q + VSTEP;
            data_d = data_q + VSTEP;
          end else if (c_q != colsM1_q) begin
            r_d       = '0;
            c_d       = c_q + C_ONE;
            colFilt_d = colFilt_q + ADDR_WIDTH'(fRows_q);
            colData_d = colData_q + ADDR_WIDTH'(dRows_q);
            filt_d    = colFilt_d;
            data_d    = colData_d;
          end else if (b_q != outM1_q) begin
            r_d        = '0;
            c_d        = '0;
            b_d        = b_q + C_ONE;
            baseData_d = baseData_q + A_ONE;
            colFilt_d  = '0;
            colData_d  = baseData_d;
            filt_d     = '0;
            data_d     = baseData_d;
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          en_d   = (r_d == nChkM1_q) ? lastMask_q : '1;
          last_d = (r_d == nChkM1_q) && (c_d == colsM1_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      filt_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      last_q  <= last_d;
      filt_q  <= filt_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  // Loop counters and address accumulators are rebuilt in INIT, so they need no reset.
  always_ff @(posedge clkIn) begin
    fRows_q    <= fRows_d;
    dRows_q    <= dRows_d;
    colsM1_q   <= colsM1_d;
    outM1_q    <= outM1_d;
    nChkM1_q   <= nChkM1_d;
    lastMask_q <= lastMask_d;
    r_q        <= r_d;
    c_q        <= c_d;
    b_q        <= b_d;
    colFilt_q  <= colFilt_d;
    colData_q  <= colData_d;
    baseData_q <= baseData_d;
  end

  assign busyOut          = busy_q;
  assign errOut           = err_q;
  assign doneOut          = done_q;
  assign beat.validOut    = valid_q;
  assign beat.filtAddrOut = filt_q;
  assign beat.dataAddrOut = data_q;
  assign beat.laneEnOut   = en_q;
  assign beat.lastOut     = last_q;

endmodule

// File: doc/cnn_conv_sequencer.md
Name: cnn_conv_sequencer

Overview:
- Loop controller for the CNN accelerator's vector multiply-and-accumulate datapath.
- After one start pulse it walks output position, filter column and row-chunk loops. Each beat carries one data-RAM vector address, one filter-RAM vector address, a lane-enable mask and a last-of-dot-product flag.
- The beat stream goes to the banked RAM read stage and then to the MAC.
- Throttled by downstream ready, which is the output FIFO's write-ready.

Parameters:
- VECTOR_SIZE, 8, lanes per beat; power of two, ≥2.
- CNT_WIDTH, 16, width of dimension inputs and loop counters.
- ADDR_WIDTH, 16, element-address width; arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clkIn, in, 1, clock.
- rstIn, in, 1, synchronous active-high reset.
- startIn, in, 1, start pulse; sampled only in IDLE.
- filtRowsIn, in, CNT_WIDTH, filter rows (vectorised dimension).
- filtColsIn, in, CNT_WIDTH, filter columns.
- dataRowsIn, in, CNT_WIDTH, data column stride in elements.
- numOutIn, in, CNT_WIDTH, number of output positions (base offsets 0..numOut-1).
- busyOut, out, 1, high in INIT and RUN.
- errOut, out, 1, one-cycle pulse on rejected start.
- doneOut, out, 1, one-cycle pulse after final beat is accepted.
- validOut, out, 1, beat valid.
- readyIn, in, 1, downstream ready.
- dataAddrOut, out, ADDR_WIDTH, data element address of lane 0.
- filtAddrOut, out, ADDR_WIDTH, filter element address of lane 0.
- laneEnOut, out, VECTOR_SIZE, per-lane read enable; bit i = lane i.
- lastOut, out, 1, final beat of the current output's dot product.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset from any state returns to IDLE on the next edge, abandons the in-flight job and discards any pending beat.
- FSM states: IDLE, INIT, RUN.
- IDLE:
  - startIn latches all config inputs.
  - Rejected start: any of filtRows, filtCols, numOut is 0, or filtRows > dataRows. Then errOut pulses in the next cycle and the FSM stays in IDLE.
  - Otherwise go to INIT.
- INIT (exactly 1 cycle):
  - Computes nChunks = ceil(filtRows/VECTOR_SIZE) and lastMask = lanes where (nChunks-1)*VECTOR_SIZE + i < filtRows.
  - Clears counters and presents beat 0. validOut is high 2 cycles after the start edge.
- Loop order, innermost first: chunk r (0..nChunks-1), column c (0..filtCols-1), base b (0..numOut-1).
- Beat fields:
  - filtAddr = c*filtRows + r*VECTOR_SIZE.
  - dataAddr = b + c*dataRows + r*VECTOR_SIZE.
  - laneEn = all ones if r < nChunks-1, else lastMask.
  - lastOut = (r == nChunks-1) && (c == filtCols-1).
- Addresses are formed by running accumulators (add VECTOR_SIZE, add stride, reload base). No multipliers are used in RUN.
- Handshake:
  - A beat transfers when validOut && readyIn at a clock edge.
  - While validOut && !readyIn, every beat output holds stable.
  - The next beat is presented on the cycle after acceptance, so holding readyIn high gives 1 beat/cycle.
  - validOut never drops without a transfer, except on reset.
- The final beat (b, c, r all at max) being accepted moves the FSM to IDLE. In that cycle: validOut←0, busyOut←0, doneOut←1 for one cycle.
- Total beats per job = numOut*filtCols*nChunks.
- startIn is ignored while busy. Config input changes during a job have no effect.
- Single-chunk case (filtRows ≤ VECTOR_SIZE): every beat uses lastMask. filtRows = VECTOR_SIZE gives an all-ones mask.
- filtCols = 1: lastOut is high on every chunk-final beat.

Test Plan:
- V=8; filtRows=3, filtCols=2, dataRows=5, numOut=2; readyIn=1.
  - Required beats (filt, data, laneEn, last): (0,0,0x07,0), (3,5,0x07,1), (0,1,0x07,0), (3,6,0x07,1).
  - First validOut 2 cycles after start; doneOut pulses on the cycle after the 4th accept.
- filtRows=20, filtCols=1, dataRows=20, numOut=1.
  - Required beats: filt/data 0/0, 8/8, 16/16; laneEn 0xFF, 0xFF, 0x0F; lastOut only on the third.
- Test 1 config with readyIn low for 3 cycles while beat 2 is valid.
  - Outputs hold (3,5,0x07,1) throughout; exactly 4 accepts in total, no duplicates or drops.
- filtCols=0 start, and separately filtRows=6 with dataRows=4.
  - errOut pulses once for each; validOut, busyOut and doneOut stay 0.
- rstIn asserted mid-run of test 1.
  - Next cycle all outputs 0 and FSM in IDLE; a new start reproduces test 1's sequence exactly.
- filtRows=8, filtCols=1, numOut=3, with startIn asserted again mid-job.
  - Required: 3 beats, data addresses 0, 1, 2, laneEn 0xFF, lastOut on each.
  - The second start is ignored; exactly one doneOut.
